// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS datapath blocks: the register-file geometry,
// the architecturally special register numbers, the stack-pointer reset value
// and the common word/register-address types.
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_addr_t;

    localparam int        NUM_REGS = 32;
    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_RA   = 5'd31;
    localparam word_t     SP_RESET = 32'd227;

endpackage : mips_pkg

// File: rtl/reg_bank.sv
// ---------------------------------------------------------------------------
// reg_bank
// MIPS general-purpose register file: 32 x DATA_W registers, two combinational
// read ports and one synchronous write port. r0 is hard-wired to zero and
// r29 ($sp) comes out of reset holding SP_RESET.
//
// Parameters:
//   DATA_W      register width in bits
//   SP_RESET    value loaded into r29 on reset
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset (wins over a write)
//   reg_write   in   write enable from the control unit
//   read_reg1   in   read port 1 address (rs)
//   read_reg2   in   read port 2 address (rt)
//   write_reg   in   write address (register-destination mux output)
//   write_data  in   write data (memory-to-register mux output)
//   read_data1  out  contents of read_reg1
//   read_data2  out  contents of read_reg2
//
// Build option:
//   REG_BANK_BYPASS_EN  when defined, a read of the register being written in
//                       the current cycle returns write_data combinationally
//                       (write-through forwarding). When undefined, reads see
//                       the array only and the new value appears after the edge.
//
// There is no handshake: the control FSM holds write_reg/write_data stable
// around the edge whenever reg_write is high.
// ---------------------------------------------------------------------------
module reg_bank #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = mips_pkg::SP_RESET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    import mips_pkg::*;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // A write actually lands only when reset is low and the target is not r0.
    // The same qualifier gates forwarding, so a dropped write is never
    // forwarded either.
    logic wr_fire;
    assign wr_fire = reg_write && !reset && (write_reg != REG_ZERO);

    // ------------------------------------------------------------------
    // Next-state of the array
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
            regs_d[REG_SP] = SP_RESET;
        end else if (wr_fire) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // ------------------------------------------------------------------
    // Read ports: identical logic replicated per port.
    // Priority: r0 -> zero, then (optional) forwarding, then array.
    // ------------------------------------------------------------------
    reg_addr_t rd_addr [2];
    assign rd_addr[0] = read_reg1;
    assign rd_addr[1] = read_reg2;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [DATA_W-1:0] port_data;

        always_comb begin
            port_data = regs_q[rd_addr[p]];
`ifdef REG_BANK_BYPASS_EN
            if (wr_fire && (rd_addr[p] == write_reg)) begin
                port_data = write_data;
            end
`endif
            // r0 reads zero regardless of what the array or bypass hold.
            if (rd_addr[p] == REG_ZERO) begin
                port_data = '0;
            end
        end
    end

    assign read_data1 = g_rd_port[0].port_data;
    assign read_data2 = g_rd_port[1].port_data;

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_reg_bank
// Self-checking bench for reg_bank. A reference array tracks what each
// register should hold; expected read values are pushed to exp_q when a read
// is set up and popped when the ports are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_reg_bank;

    localparam int          W      = 32;
    localparam logic [31:0] SP_VAL = 32'd227;

    logic         clk;
    logic         reset;
    logic         reg_write;
    logic [4:0]   read_reg1;
    logic [4:0]   read_reg2;
    logic [4:0]   write_reg;
    logic [W-1:0] write_data;
    logic [W-1:0] read_data1;
    logic [W-1:0] read_data2;

    reg_bank #(
        .DATA_W   (W),
        .SP_RESET (SP_VAL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q [$];
    logic [W-1:0] mdl [32];
    int           n_checks;
    int           n_fails;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pop one expectation and compare it with an observed port value.
    task automatic sb_compare(input string tag, input logic [W-1:0] got);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s: got %h expected <empty scoreboard>", tag, got);
        end else begin
            check(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        mdl[29] = SP_VAL;
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------

    // Set both read addresses, queue the expected data, sample on negedge.
    task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [W-1:0] e1, input logic [W-1:0] e2);
        read_reg1 = a1;
        read_reg2 = a2;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        @(negedge clk);
        sb_compare({tag, "_p1"}, read_data1);
        sb_compare({tag, "_p2"}, read_data2);
    endtask

    // One-cycle write; the model is updated the way the register file should
    // behave (r0 and reset-colliding writes are dropped).
    task automatic wr(input logic [4:0] a, input logic [W-1:0] d, input logic en);
        @(posedge clk);
        #1;
        reg_write  = en;
        write_reg  = a;
        write_data = d;
        @(posedge clk);
        if (reset) model_reset();
        else if (en && a != 5'd0) mdl[a] = d;
        #1;
        reg_write = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        n_checks   = 0;
        n_fails    = 0;
        reset      = 1'b1;
        reg_write  = 1'b0;
        read_reg1  = '0;
        read_reg2  = '0;
        write_reg  = '0;
        write_data = '0;
        model_reset();

        // Reset for one edge, then sweep every address on both ports.
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd("reset_sweep", 5'(i), 5'(31 - i),
               (i == 29) ? SP_VAL : 32'h0, ((31 - i) == 29) ? SP_VAL : 32'h0);
        end

        // Basic write then read on both ports; neighbour untouched.
        wr(5'd8, 32'hDEADBEEF, 1'b1);
        rd("wr_r8", 5'd8, 5'd8, 32'hDEADBEEF, 32'hDEADBEEF);
        rd("r9_clean", 5'd9, 5'd0, 32'h0, 32'h0);

        // r0 protection, including a read of r0 while r0 is being written.
        @(posedge clk);
        #1;
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'hFFFFFFFF;
        read_reg1  = 5'd0;
        read_reg2  = 5'd8;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        sb_compare("r0_during_wr_p1", read_data1);
        sb_compare("r0_during_wr_p2", read_data2);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        rd("r0_after_wr", 5'd0, 5'd0, 32'h0, 32'h0);

        // jal path: r31 is a normal write, $sp unaffected.
        wr(5'd31, 32'h00000044, 1'b1);
        rd("jal_ra", 5'd31, 5'd29, 32'h00000044, SP_VAL);

        // Read-during-write on r5 (old 1, new 2).
        wr(5'd5, 32'h1, 1'b1);
        @(posedge clk);
        #1;
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'h2;
        read_reg1  = 5'd5;
        read_reg2  = 5'd8;
`ifdef REG_BANK_BYPASS_EN
        exp_q.push_back(32'h2);
`else
        exp_q.push_back(32'h1);
`endif
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        sb_compare("rdw_same_cycle_p1", read_data1);
        sb_compare("rdw_other_p2", read_data2);
        @(posedge clk);
        mdl[5] = 32'h2;
        #1;
        reg_write = 1'b0;
        rd("rdw_after_edge", 5'd5, 5'd5, 32'h2, 32'h2);

        // Random writes (some disabled, some to r0) checked against the model.
        for (int k = 0; k < 40; k++) begin
            logic [4:0]   a;
            logic [W-1:0] d;
            logic         en;
            logic [4:0]   r1;
            logic [4:0]   r2;
            a  = 5'($urandom_range(0, 31));
            d  = $urandom();
            en = 1'($urandom_range(0, 3) != 0);
            wr(a, d, en);
            r1 = a;
            r2 = 5'($urandom_range(0, 31));
            rd("rand", r1, r2, (r1 == 5'd0) ? 32'h0 : mdl[r1], (r2 == 5'd0) ? 32'h0 : mdl[r2]);
        end

        // Reset vs write collision on r29: reset wins, array fully cleared.
        @(posedge clk);
        #1;
        reset      = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd29;
        write_data = 32'h1234;
        @(posedge clk);
        model_reset();
        #1;
        reset     = 1'b0;
        reg_write = 1'b0;
        rd("collision_sp", 5'd29, 5'd8, SP_VAL, 32'h0);
        rd("collision_ra", 5'd31, 5'd5, 32'h0, 32'h0);

        // Reads after reset follow the model for a final full sweep.
        for (int i = 0; i < 32; i++) begin
            rd("post_reset", 5'(i), 5'(i), mdl[i], mdl[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion before 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_reg_bank
